register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/rf_cell.sv | 54 +++++
 rtl/register_file.sv | 91 +++++++++
 tb/tb_register_file.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register file.
//   FS_*  : FunSel operation codes applied to every enabled register.
//   SEL_* : 3-bit read-select codes for O1Sel/O2Sel.
package regfile_pkg;

  localparam logic [1:0] FS_DEC  = 2'd0;
  localparam logic [1:0] FS_INC  = 2'd1;
  localparam logic [1:0] FS_LOAD = 2'd2;
  localparam logic [1:0] FS_CLR  = 2'd3;

  localparam logic [2:0] SEL_T1 = 3'b000;
  localparam logic [2:0] SEL_T2 = 3'b001;
  localparam logic [2:0] SEL_T3 = 3'b010;
  localparam logic [2:0] SEL_T4 = 3'b011;
  localparam logic [2:0] SEL_R1 = 3'b100;
  localparam logic [2:0] SEL_R2 = 3'b101;
  localparam logic [2:0] SEL_R3 = 3'b110;
  localparam logic [2:0] SEL_R4 = 3'b111;

endpackage

// File: rtl/rf_cell.sv
// rf_cell: one N-bit register of the register file.
// Ports:
//   CLK    - clock, state updates on rising edge
//   RST    - asynchronous active-high reset, clears the register
//   E      - enable; register changes only when high
//   FunSel - operation (decrement, increment, load I, clear)
//   I      - load data
//   Q      - current register contents
//   Q_next - value the register takes at the next edge (0 while RST is high)
module rf_cell
  import regfile_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         E,
  input  logic [1:0]   FunSel,
  input  logic [N-1:0] I,
  output logic [N-1:0] Q,
  output logic [N-1:0] Q_next
);

  localparam logic [N-1:0] One = N'(1);

  logic [N-1:0] r_q;
  logic [N-1:0] w_next;

  always_comb begin
    w_next = r_q;
    if (E) begin
      unique case (FunSel)
        FS_DEC:  w_next = r_q - One;
        FS_INC:  w_next = r_q + One;
        FS_LOAD: w_next = I;
        FS_CLR:  w_next = '0;
        default: w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= '0;
    end else begin
      r_q <= w_next;
    end
  end

  assign Q = r_q;
  // A pending write must not leak to the outputs while reset holds the cell at 0.
  assign Q_next = RST ? '0 : w_next;

endmodule

// File: rtl/register_file.sv
// register_file: four general (R1-R4) and four temporary (T1-T4) N-bit registers
// sharing one load bus and one operation code, with two combinational read ports.
// Ports:
//   CLK, RST      - clock; asynchronous active-high reset clearing all registers
//   I             - load data for every register
//   FunSel        - 0 dec, 1 inc, 2 load I, 3 clear, applied to every enabled register
//   RSel          - enables, bit3 R1 .. bit0 R4
//   TSel          - enables, bit3 T1 .. bit0 T4
//   O1Sel, O2Sel  - read selects (000 T1 .. 011 T4, 100 R1 .. 111 R4)
//   O1, O2        - selected register contents
// Configuration: define REGFILE_BYPASS_EN to make the read ports show the value an
// enabled register is about to take (write-through); undefined, reads show stored
// contents only.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] I,
  input  logic [1:0]   FunSel,
  input  logic [3:0]   RSel,
  input  logic [3:0]   TSel,
  input  logic [2:0]   O1Sel,
  input  logic [2:0]   O2Sel,
  output logic [N-1:0] O1,
  output logic [N-1:0] O2
);

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  // Cell index equals its read-select code: 0..3 T1..T4, 4..7 R1..R4.
  logic [7:0]   w_en;
  logic [N-1:0] w_q    [8];
  logic [N-1:0] w_next [8];
  logic [N-1:0] w_rd   [8];

  assign w_en = {RSel[0], RSel[1], RSel[2], RSel[3], TSel[0], TSel[1], TSel[2], TSel[3]};

  for (genvar k = 0; k < 8; k++) begin : g_cell
    rf_cell #(
      .N(N)
    ) u_cell (
      .CLK   (CLK),
      .RST   (RST),
      .E     (w_en[k]),
      .FunSel(FunSel),
      .I     (I),
      .Q     (w_q[k]),
      .Q_next(w_next[k])
    );
    // Constant select: without bypass the output path sees register state only.
    assign w_rd[k] = Bypass ? w_next[k] : w_q[k];
  end

  always_comb begin
    O1 = w_rd[0];
    unique case (O1Sel)
      SEL_T1:  O1 = w_rd[0];
      SEL_T2:  O1 = w_rd[1];
      SEL_T3:  O1 = w_rd[2];
      SEL_T4:  O1 = w_rd[3];
      SEL_R1:  O1 = w_rd[4];
      SEL_R2:  O1 = w_rd[5];
      SEL_R3:  O1 = w_rd[6];
      SEL_R4:  O1 = w_rd[7];
      default: O1 = w_rd[0];
    endcase
  end

  always_comb begin
    O2 = w_rd[0];
    unique case (O2Sel)
      SEL_T1:  O2 = w_rd[0];
      SEL_T2:  O2 = w_rd[1];
      SEL_T3:  O2 = w_rd[2];
      SEL_T4:  O2 = w_rd[3];
      SEL_R1:  O2 = w_rd[4];
      SEL_R2:  O2 = w_rd[5];
      SEL_R3:  O2 = w_rd[6];
      SEL_R4:  O2 = w_rd[7];
      default: O2 = w_rd[0];
    endcase
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file (N = 8).
// Expected read values are pushed to a scoreboard queue from a behavioural model
// and popped for comparison once the outputs have settled.
module tb_register_file;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] I = '0;
  logic [1:0] FunSel = '0;
  logic [3:0] RSel = '0;
  logic [3:0] TSel = '0;
  logic [2:0] O1Sel = '0;
  logic [2:0] O2Sel = '0;
  logic [7:0] O1;
  logic [7:0] O2;

  int checks = 0;
  int errors = 0;

  // Model indexed by read-select code: 0..3 T1..T4, 4..7 R1..R4.
  logic [7:0] model [8];
  logic [7:0] exp_q [$];

  register_file #(
    .N(8)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .I     (I),
    .FunSel(FunSel),
    .RSel  (RSel),
    .TSel  (TSel),
    .O1Sel (O1Sel),
    .O2Sel (O2Sel),
    .O1    (O1),
    .O2    (O2)
  );

  always #10 CLK = ~CLK;

  function automatic logic [7:0] op(input logic [7:0] q, input logic [1:0] fs,
                                    input logic [7:0] d);
    case (fs)
      2'd0:    return q - 8'd1;
      2'd1:    return q + 8'd1;
      2'd2:    return d;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic enabled(input int k, input logic [3:0] rs, input logic [3:0] ts);
    return (k < 4) ? ts[3-k] : rs[7-k];
  endfunction

  // Pop two expected values and compare against the live outputs.
  task automatic drain(input string tag);
    logic [7:0] e1;
    logic [7:0] e2;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    checks++;
    assert (O1 === e1) else begin
      errors++;
      $error("FAIL %s O1 got %h expected %h", tag, O1, e1);
    end
    checks++;
    assert (O2 === e2) else begin
      errors++;
      $error("FAIL %s O2 got %h expected %h", tag, O2, e2);
    end
  endtask

  // Read two registers (no enables active) and check against the model.
  task automatic check(input logic [2:0] s1, input logic [2:0] s2, input string tag);
    O1Sel = s1;
    O2Sel = s2;
    exp_q.push_back(model[s1]);
    exp_q.push_back(model[s2]);
    #1;
    drain(tag);
  endtask

  task automatic check_all(input string tag);
    for (int s = 0; s < 8; s++) check(3'(s), 3'(7 - s), tag);
  endtask

  // One clocked operation; enables are dropped just after the edge.
  task automatic step(input logic [1:0] fs, input logic [3:0] rs, input logic [3:0] ts,
                      input logic [7:0] d);
    @(negedge CLK);
    FunSel = fs;
    RSel   = rs;
    TSel   = ts;
    I      = d;
    @(posedge CLK);
    for (int k = 0; k < 8; k++) if (enabled(k, rs, ts)) model[k] = op(model[k], fs, d);
    #1;
    RSel = '0;
    TSel = '0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    #2;
    RST = 1'b0;
    for (int k = 0; k < 8; k++) model[k] = '0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) model[k] = '0;

    // Reset state
    #3;
    check(3'b000, 3'b100, "reset_state_a");
    check(3'b011, 3'b111, "reset_state_b");
    @(negedge CLK);
    RST = 1'b0;

    // Load A5 into R1 only
    step(2'd2, 4'b1000, 4'b0000, 8'hA5);
    check(3'b100, 3'b000, "load_r1");
    check_all("load_r1_others");

    // Decrement from 0 wraps, then increment twice
    pulse_reset();
    step(2'd0, 4'b0000, 4'b0001, 8'h00);
    check(3'b011, 3'b011, "t4_dec_wrap");
    step(2'd1, 4'b0000, 4'b0001, 8'h00);
    step(2'd1, 4'b0000, 4'b0001, 8'h00);
    check(3'b011, 3'b000, "t4_inc_twice");

    // Broadcast load, then partial clear
    step(2'd2, 4'b1111, 4'b1111, 8'h3C);
    check_all("load_all_3c");
    step(2'd3, 4'b0101, 4'b0000, 8'h00);
    check_all("clr_r2_r4");

    // Same select on both ports, then idle edges hold state
    step(2'd2, 4'b0010, 4'b0000, 8'h7E);
    check(3'b110, 3'b110, "r3_dual_read");
    @(negedge CLK);
    FunSel = 2'd3;
    I = 8'hFF;
    repeat (5) @(posedge CLK);
    check(3'b110, 3'b110, "r3_hold_idle");
    check_all("hold_idle_all");

    // Increment wraps all-ones to zero; mixed inc across R and T
    step(2'd2, 4'b0001, 4'b0100, 8'hFF);
    step(2'd1, 4'b0001, 4'b0100, 8'h00);
    check(3'b111, 3'b001, "inc_wrap");
    step(2'd1, 4'b1000, 4'b1000, 8'h00);
    check(3'b100, 3'b000, "inc_r1_t1");

    // Write-through visibility before the edge
    step(2'd2, 4'b0100, 4'b0000, 8'h55);
    @(negedge CLK);
    FunSel = 2'd2;
    I      = 8'h11;
    RSel   = 4'b0100;
    O1Sel  = 3'b101;
    O2Sel  = 3'b110;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(8'h11);
`else
    exp_q.push_back(model[5]);
`endif
    exp_q.push_back(model[6]);
    #1;
    drain("bypass_pre_edge");
    @(posedge CLK);
    model[5] = 8'h11;
    #1;
    RSel = '0;
    check(3'b101, 3'b110, "bypass_post_edge");

    // Asynchronous reset mid-cycle with an operation pending
    step(2'd2, 4'b1111, 4'b1111, 8'h5A);
    check_all("load_all_5a");
    @(negedge CLK);
    FunSel = 2'd2;
    I      = 8'hC3;
    RSel   = 4'b1111;
    TSel   = 4'b1111;
    #1;
    RST = 1'b1;
    for (int k = 0; k < 8; k++) model[k] = '0;
    for (int s = 0; s < 8; s++) begin
      O1Sel = 3'(s);
      O2Sel = 3'(s);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      #1;
      drain("async_reset");
    end
    @(posedge CLK);
    #1;
    check_all("reset_dominates_edge");
    @(negedge CLK);
    RSel = '0;
    TSel = '0;
    RST  = 1'b0;

    // First operation after reset acts on zero
    step(2'd0, 4'b1000, 4'b0000, 8'h00);
    check(3'b100, 3'b101, "post_reset_dec");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
